// File: rtl/pux_pkg.sv
// Shared encodings for the PUX opcode scheduler: command/select fields,
// scheduler FSM states and status-word bit placement.
package pux_pkg;

   typedef enum logic [1:0] {
      PUX_CMD_NOP  = 2'd0,
      PUX_CMD_LOAD = 2'd1,
      PUX_CMD_EXEC = 2'd2,
      PUX_CMD_STAT = 2'd3
   } pux_cmd_e;

   typedef enum logic [1:0] {
      PUX_SEL_A = 2'd0,
      PUX_SEL_B = 2'd1,
      PUX_SEL_M = 2'd2
   } pux_sel_e;

   localparam logic [1:0] PUX_SEL_ILLEGAL = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DISPATCH = 3'd1,
      ST_LOAD     = 3'd2,
      ST_START    = 3'd3,
      ST_WAIT     = 3'd4,
      ST_STATUS   = 3'd5
   } pux_state_e;

   // Sticky flags sit at the top of the status word, counted down from the MSB.
   localparam int PUX_STAT_ERR_FROM_MSB = 0;
   localparam int PUX_STAT_ILL_FROM_MSB = 1;
   localparam int PUX_STAT_CNT_LSB      = 0;

endpackage

// File: rtl/pux_opfifo.sv
// Synchronous opcode FIFO with wrap-bit pointers; exposes full, empty and
// the number of free entries.
module pux_opfifo #(
   parameter int W  = 8,
   parameter int AW = 3
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   free_o
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wptr_q, rptr_q;
   logic [AW:0]  used;
   logic         doPush, doPop;

   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty_o = (wptr_q == rptr_q);
   // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;
   assign used    = wptr_q - rptr_q;
   assign free_o  = (AW+1)'(DEPTH) - used;
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (doPush) wptr_q <= wptr_q + (AW+1)'(1);
         if (doPop)  rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (doPush) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/pux_sched.sv
// PUX opcode scheduler: buffers opcodes, decodes them one at a time and
// sequences operand loads, core execution and status emission.
module pux_sched
   import pux_pkg::*;
#(
   parameter int OPCW    = 8,
   parameter int DATAW   = 16,
   parameter int OPFIFOW = 3,
   parameter int NWORDS  = 4
) (
   input  logic              axis_clk,
   input  logic              axis_rstn,
   input  logic [OPCW-1:0]   axis_opcode_data,
   input  logic              axis_opcode_valid,
   output logic              axis_opcode_ready,
   output logic              ld_en,
   output logic [1:0]        ld_sel,
   input  logic              ld_beat,
   output logic              core_start,
   output logic [OPCW-5:0]   core_func,
   input  logic              core_done,
   input  logic              core_err,
   output logic [DATAW-1:0]  axis_status_data,
   output logic              axis_status_valid,
   input  logic              axis_status_ready,
   output logic              stream_request
);

   localparam int BCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [OPFIFOW:0] HALF_FREE = (OPFIFOW+1)'(1 << (OPFIFOW-1));

   pux_state_e        state_q, state_d;
   logic [OPCW-1:0]   cur_op_q, cur_op_d;
   logic [OPCW-5:0]   func_q, func_d;
   logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
   logic [DATAW-3:0]  exec_cnt_q, exec_cnt_d;
   logic              err_q, err_d;
   logic              ill_q, ill_d;
   logic              stream_q;

   logic [OPCW-1:0]   fifoHead;
   logic              fifoFull, fifoEmpty, fifoPop;
   logic [OPFIFOW:0]  fifoFree;
   logic [DATAW-1:0]  statusWord;

   assign fifoPop = (state_q == ST_IDLE) && !fifoEmpty;

   pux_opfifo #(.W(OPCW), .AW(OPFIFOW)) u_opfifo (
      .clk_i   (axis_clk),
      .rst_ni  (axis_rstn),
      .push_i  (axis_opcode_valid),
      .pop_i   (fifoPop),
      .wdata_i (axis_opcode_data),
      .rdata_o (fifoHead),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .free_o  (fifoFree)
   );

   always_ff @(posedge axis_clk or negedge axis_rstn) begin
      if (!axis_rstn) begin
         state_q    <= ST_IDLE;
         cur_op_q   <= '0;
         func_q     <= '0;
         beat_cnt_q <= '0;
         exec_cnt_q <= '0;
         err_q      <= 1'b0;
         ill_q      <= 1'b0;
         stream_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         cur_op_q   <= cur_op_d;
         func_q     <= func_d;
         beat_cnt_q <= beat_cnt_d;
         exec_cnt_q <= exec_cnt_d;
         err_q      <= err_d;
         ill_q      <= ill_d;
         stream_q   <= (fifoFree >= HALF_FREE);
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_op_d   = cur_op_q;
      func_d     = func_q;
      beat_cnt_d = beat_cnt_q;
      exec_cnt_d = exec_cnt_q;
      err_d      = err_q;
      ill_d      = ill_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifoEmpty) begin
               cur_op_d = fifoHead;
               state_d  = ST_DISPATCH;
            end
         end
         ST_DISPATCH: begin
            case (pux_cmd_e'(cur_op_q[1:0]))
               PUX_CMD_NOP:  state_d = ST_IDLE;
               PUX_CMD_LOAD: begin
                  if (cur_op_q[3:2] == PUX_SEL_ILLEGAL) begin
                     ill_d   = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_LOAD;
                  end
               end
               PUX_CMD_EXEC: begin
                  func_d  = cur_op_q[OPCW-1:4];
                  state_d = ST_START;
               end
               PUX_CMD_STAT: state_d = ST_STATUS;
               default:      state_d = ST_IDLE;
            endcase
         end
         ST_LOAD: begin
            if (ld_beat) begin
               if (beat_cnt_q == BCW'(NWORDS-1)) begin
                  beat_cnt_d = '0;
                  state_d    = ST_IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + BCW'(1);
               end
            end
         end
         ST_START: state_d = ST_WAIT;
         ST_WAIT: begin
            if (core_done) begin
               err_d      = err_q | core_err;
               exec_cnt_d = exec_cnt_q + (DATAW-2)'(1);
               state_d    = ST_IDLE;
            end
         end
         ST_STATUS: begin
            if (axis_status_ready) begin
               err_d   = 1'b0;
               ill_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      statusWord = '0;
      statusWord[DATAW-1-PUX_STAT_ERR_FROM_MSB] = err_q;
      statusWord[DATAW-1-PUX_STAT_ILL_FROM_MSB] = ill_q;
      statusWord[DATAW-3:PUX_STAT_CNT_LSB]      = exec_cnt_q;
   end

   // Handshake outputs decode straight from the state register so an async
   // reset drops them immediately.
   assign axis_opcode_ready = !fifoFull;
   assign ld_en             = (state_q == ST_LOAD);
   assign ld_sel            = (state_q == ST_LOAD) ? cur_op_q[3:2] : 2'b00;
   assign core_start        = (state_q == ST_START);
   assign core_func         = func_q;
   assign axis_status_valid = (state_q == ST_STATUS);
   assign axis_status_data  = (state_q == ST_STATUS) ? statusWord : '0;
   assign stream_request    = stream_q;

endmodule

// File: tb/tb_pux_sched.sv
// Directed scoreboard bench for pux_sched: expected load selects, function
// codes and status words are queued at push time and checked on output.
module tb_pux_sched;

   localparam int OPCW    = 8;
   localparam int DATAW   = 16;
   localparam int OPFIFOW = 3;
   localparam int NWORDS  = 4;
   localparam int TMO     = 60;

   logic              clk = 1'b0;
   logic              rstn;
   logic [OPCW-1:0]   opData;
   logic              opValid, opReady;
   logic              ldEn, ldBeat;
   logic [1:0]        ldSel;
   logic              coreStart, coreDone, coreErr;
   logic [OPCW-5:0]   coreFunc;
   logic [DATAW-1:0]  stData;
   logic              stValid, stReady;
   logic              streamReq;

   int checks = 0;
   int errors = 0;

   logic [DATAW-1:0]  statusQ[$];
   logic [OPCW-5:0]   funcQ[$];
   logic [1:0]        selQ[$];
   logic              mErr, mIll;
   logic [DATAW-3:0]  mExec;

   always #5 clk = ~clk;

   pux_sched #(.OPCW(OPCW), .DATAW(DATAW), .OPFIFOW(OPFIFOW), .NWORDS(NWORDS)) dut (
      .axis_clk          (clk),
      .axis_rstn         (rstn),
      .axis_opcode_data  (opData),
      .axis_opcode_valid (opValid),
      .axis_opcode_ready (opReady),
      .ld_en             (ldEn),
      .ld_sel            (ldSel),
      .ld_beat           (ldBeat),
      .core_start        (coreStart),
      .core_func         (coreFunc),
      .core_done         (coreDone),
      .core_err          (coreErr),
      .axis_status_data  (stData),
      .axis_status_valid (stValid),
      .axis_status_ready (stReady),
      .stream_request    (streamReq)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [OPCW-1:0] op);
      bit taken = 1'b0;
      opData  = op;
      opValid = 1'b1;
      for (int i = 0; i < TMO && !taken; i++) begin
         if (opReady) taken = 1'b1;
         @(negedge clk);
      end
      opValid = 1'b0;
      checkOutput("push_accept", 32'(taken), 32'd1);
   endtask

   // Update the reference model in program order, then drive the opcode.
   task automatic pushOp(input logic [OPCW-1:0] op);
      case (op[1:0])
         2'd1: if (op[3:2] == 2'd3) mIll = 1'b1; else selQ.push_back(op[3:2]);
         2'd2: funcQ.push_back(op[OPCW-1:4]);
         2'd3: begin
            statusQ.push_back({mErr, mIll, mExec});
            mErr = 1'b0;
            mIll = 1'b0;
         end
         default: ;
      endcase
      applyStimulus(op);
   endtask

   task automatic waitFor(input int which, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < TMO && !seen; i++) begin
         if ((which == 0 && ldEn) || (which == 1 && coreStart) || (which == 2 && stValid))
            seen = 1'b1;
         else
            @(negedge clk);
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   task automatic checkSel();
      if (selQ.size() == 0) checkOutput("sel_queue_underflow", 32'd0, 32'd1);
      else checkOutput("ld_sel", 32'(ldSel), 32'(selQ.pop_front()));
   endtask

   task automatic runBeats();
      for (int b = 0; b < NWORDS; b++) begin
         checkOutput("ld_en_beat", 32'(ldEn), 32'd1);
         ldBeat = 1'b1;
         @(negedge clk);
         ldBeat = 1'b0;
         if (b == NWORDS-1) begin
            checkOutput("ld_en_after_last", 32'(ldEn), 32'd0);
         end else begin
            checkOutput("ld_en_gap", 32'(ldEn), 32'd1);
            @(negedge clk);
         end
      end
   endtask

   task automatic startedExec();
      logic [OPCW-5:0] f;
      waitFor(1, "core_start_seen");
      if (funcQ.size() == 0) begin
         checkOutput("func_queue_underflow", 32'd0, 32'd1);
         f = '0;
      end else begin
         f = funcQ.pop_front();
         checkOutput("core_func", 32'(coreFunc), 32'(f));
      end
      @(negedge clk);
      checkOutput("core_start_pulse", 32'(coreStart), 32'd0);
      checkOutput("core_func_hold", 32'(coreFunc), 32'(f));
   endtask

   task automatic finishExec(input logic err, input int delay);
      repeat (delay) @(negedge clk);
      coreDone = 1'b1;
      coreErr  = err;
      @(negedge clk);
      coreDone = 1'b0;
      coreErr  = 1'b0;
      mErr     = mErr | err;
      mExec    = mExec + 1'b1;
   endtask

   task automatic serviceStatus(input int hold);
      logic [DATAW-1:0] exp;
      waitFor(2, "status_valid_seen");
      if (statusQ.size() == 0) begin
         checkOutput("status_queue_underflow", 32'd0, 32'd1);
         exp = '0;
      end else begin
         exp = statusQ.pop_front();
      end
      checkOutput("status_data", 32'(stData), 32'(exp));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("status_hold", 32'({stValid, stData}), 32'({1'b1, exp}));
      end
      stReady = 1'b1;
      @(negedge clk);
      stReady = 1'b0;
      checkOutput("status_valid_drop", 32'(stValid), 32'd0);
   endtask

   task automatic checkReset();
      checkOutput("rst_ready", 32'(opReady), 32'd1);
      checkOutput("rst_stream", 32'(streamReq), 32'd1);
      checkOutput("rst_ld", 32'({ldEn, ldSel}), 32'd0);
      checkOutput("rst_core", 32'({coreStart, coreFunc}), 32'd0);
      checkOutput("rst_status", 32'({stValid, stData}), 32'd0);
   endtask

   task automatic doReset();
      rstn = 1'b0;
      {opValid, ldBeat, coreDone, coreErr, stReady} = '0;
      opData = '0;
      {mErr, mIll} = 2'b00;
      mExec = '0;
      statusQ.delete();
      funcQ.delete();
      selQ.delete();
      repeat (2) @(negedge clk);
      checkReset();
      rstn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [OPCW-1:0] op;
      doReset();

      $display("[TB] NOP passes through without side effects");
      pushOp(8'h00);
      for (int i = 0; i < 4; i++) begin
         checkOutput("nop_quiet", 32'({ldEn, coreStart, stValid}), 32'd0);
         checkOutput("nop_ready", 32'({opReady, streamReq}), 32'd3);
         @(negedge clk);
      end

      $display("[TB] LOAD sel=B with sparse beats");
      pushOp(8'h05);
      waitFor(0, "ld_en_seen");
      checkSel();
      runBeats();

      $display("[TB] EXEC with error, then two STATs");
      pushOp(8'hA2);
      startedExec();
      finishExec(1'b1, 4);
      pushOp(8'h03);
      serviceStatus(3);
      pushOp(8'h03);
      serviceStatus(0);

      $display("[TB] fill FIFO while stalled in WAIT");
      pushOp(8'h52);
      startedExec();
      for (int k = 1; k <= 8; k++) begin
         op = {4'(k), 4'b0010};
         pushOp(op);
         @(negedge clk);
         checkOutput("ready_fill", 32'(opReady), 32'(k < 8));
         checkOutput("stream_fill", 32'(streamReq), 32'((8 - k) >= 4));
      end
      funcQ.push_back(4'd9);
      opData  = 8'h92;
      opValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("ready_full", 32'(opReady), 32'd0);
      end
      finishExec(1'b0, 0);
      begin
         bit taken = 1'b0;
         for (int i = 0; i < TMO && !taken; i++) begin
            if (opReady) taken = 1'b1;
            @(negedge clk);
         end
         opValid = 1'b0;
         checkOutput("push9_accept", 32'(taken), 32'd1);
      end
      for (int k = 0; k < 9; k++) begin
         startedExec();
         finishExec(1'b0, 1);
      end
      repeat (2) @(negedge clk);
      checkOutput("stream_drained", 32'(streamReq), 32'd1);

      $display("[TB] illegal LOAD sets sticky flag");
      doReset();
      pushOp(8'h0D);
      for (int i = 0; i < 4; i++) begin
         checkOutput("illegal_no_ld", 32'(ldEn), 32'd0);
         @(negedge clk);
      end
      pushOp(8'h03);
      serviceStatus(0);

      $display("[TB] reset mid-LOAD");
      pushOp(8'h09);
      applyStimulus(8'h03);
      waitFor(0, "ld_en_m_seen");
      checkSel();
      ldBeat = 1'b1;
      repeat (2) @(negedge clk);
      ldBeat = 1'b0;
      checkOutput("ld_en_mid", 32'(ldEn), 32'd1);
      rstn = 1'b0;
      #1;
      checkOutput("ld_en_async_drop", 32'(ldEn), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      {mErr, mIll} = 2'b00;
      mExec = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("fifo_flushed", 32'({stValid, ldEn, opReady}), 32'd1);
      end
      pushOp(8'h05);
      waitFor(0, "ld_en_restart_seen");
      checkSel();
      runBeats();

      checkOutput("queues_drained", 32'(statusQ.size() + funcQ.size() + selQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
